// File: rtl/wb_cmd_master.sv
// Command-to-Wishbone bridge: takes one command at a time, runs a classic
// Wishbone cycle (or flags a decode error) and returns a response with timeout.
module wb_cmd_master #(
  parameter int unsigned NUM_SLAVE = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_wbm_cyc,
  output logic        o_wbm_stb,
  output logic        o_wbm_we,
  output logic [31:0] o_wbm_addr,
  output logic [31:0] o_wbm_data,
  input  logic [31:0] i_wbm_data,
  input  logic        i_wbm_ack,
  output logic [7:0]  o_err_cnt
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_BUS  = 2'd1;
  localparam logic [1:0]  ST_RESP = 2'd2;
  localparam logic [8:0]  NUM_SLAVE_L  = 9'(NUM_SLAVE);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] wait_q, wait_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_inc_s;

  // Next-state and datapath decode for the IDLE/BUS/RESP controller.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    wait_d      = wait_q;
    err_inc_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_data;
          // Out-of-range select never reaches the bus.
          if ({1'b0, i_cmd_addr[15:8]} >= NUM_SLAVE_L) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'h0000_0000;
            err_inc_s   = 1'b1;
          end else begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            wait_d  = 16'h0000;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // Ack is tested first so it wins over a same-edge timeout.
        if (i_wbm_ack) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = we_q ? 32'h0000_0000 : i_wbm_data;
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'h0000_0000;
          err_inc_s   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Error counter and ready flag are derived from the decoded next state.
  always_comb begin
    if (err_inc_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      wait_q      <= 16'h0000;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      wait_q      <= wait_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_wbm_cyc   = cyc_q;
  assign o_wbm_stb   = cyc_q;
  assign o_wbm_we    = we_q;
  assign o_wbm_addr  = addr_q;
  assign o_wbm_data  = wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master (NUM_SLAVE=3, TIMEOUT=8); inputs driven
// and outputs sampled on the falling clock edge.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid, i_cmd_we, i_rsp_ready, i_wbm_ack;
  logic [31:0] i_cmd_addr, i_cmd_data, i_wbm_data;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_err;
  logic        o_wbm_cyc, o_wbm_stb, o_wbm_we;
  logic [31:0] o_rsp_data, o_wbm_addr, o_wbm_data;
  logic [7:0]  o_err_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  rsp_t     exp_q[$];
  int       checks = 0;
  int       errors = 0;
  int       exp_err_cnt = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.NUM_SLAVE(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_wbm_cyc(o_wbm_cyc), .o_wbm_stb(o_wbm_stb), .o_wbm_we(o_wbm_we),
    .o_wbm_addr(o_wbm_addr), .o_wbm_data(o_wbm_data),
    .i_wbm_data(i_wbm_data), .i_wbm_ack(i_wbm_ack), .o_err_cnt(o_err_cnt)
  );

  // Present a command at a falling edge and hold it until accepted.
  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data);
    i_cmd_we = we; i_cmd_addr = addr; i_cmd_data = data; i_cmd_valid = 1'b1;
    for (int n = 0; n < 20 && !o_cmd_ready; n++) @(negedge clk);
    if (!o_cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready=%0b required 1", o_cmd_ready);
    end
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  // Act as the slave: count cycles with cyc high, ack on cycle ack_cyc (0 = never).
  task automatic run_bus(input int ack_cyc, input logic [31:0] ack_data, output int cnt);
    cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      if (!o_wbm_cyc) break;
      cnt++;
      if (n == ack_cyc) begin
        i_wbm_ack = 1'b1; i_wbm_data = ack_data;
      end
      @(negedge clk);
      i_wbm_ack = 1'b0;
    end
  endtask

  // Wait (bounded) for a response and consume it.
  task automatic drain_rsp(output logic [31:0] d, output logic e, output logic got);
    for (int n = 0; n < 20 && !o_rsp_valid; n++) @(negedge clk);
    got = o_rsp_valid; d = o_rsp_data; e = o_rsp_err;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = 32'h0; i_cmd_data = 32'h0;
    i_rsp_ready = 1'b0; i_wbm_ack = 1'b0; i_wbm_data = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_wbm_cyc, o_wbm_stb, o_wbm_we, o_rsp_valid, o_rsp_err} !== 5'b00000 ||
        o_wbm_addr !== 32'h0 || o_wbm_data !== 32'h0 || o_rsp_data !== 32'h0 || o_err_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: cyc=%b stb=%b we=%b rv=%b re=%b addr=%h wd=%h rd=%h ec=%0d required all 0",
               o_wbm_cyc, o_wbm_stb, o_wbm_we, o_rsp_valid, o_rsp_err, o_wbm_addr, o_wbm_data, o_rsp_data, o_err_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: cmd_ready=%b required 1", o_cmd_ready);
    end
    // Stray acks while idle must not create a response or a cycle.
    i_wbm_ack = 1'b1; i_wbm_data = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    i_wbm_ack = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_wbm_cyc !== 1'b0) begin
      errors++; $display("FAIL idle_ack: rsp_valid=%b cyc=%b required 0 0", o_rsp_valid, o_wbm_cyc);
    end
  endtask

  task automatic test_read;
    int cnt; logic [31:0] d; logic e, got; rsp_t x;
    exp_q.push_back('{d: 32'hCAFE_F00D, e: 1'b0});
    send_cmd(1'b0, 32'h0000_0100, 32'h0);
    checks++;
    if (o_wbm_cyc !== 1'b1 || o_wbm_stb !== 1'b1 || o_wbm_we !== 1'b0 || o_wbm_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL read_bus: cyc=%b stb=%b we=%b addr=%h required 1 1 0 00000100",
                         o_wbm_cyc, o_wbm_stb, o_wbm_we, o_wbm_addr);
    end
    run_bus(2, 32'hCAFE_F00D, cnt);
    checks++;
    if (cnt != 2) begin errors++; $display("FAIL read_cyc_len: got %0d required 2", cnt); end
    drain_rsp(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (got !== 1'b1 || d !== x.d || e !== x.e) begin
      errors++; $display("FAIL read_rsp: valid=%b data=%h err=%b required 1 %h %b", got, d, e, x.d, x.e);
    end
    checks++;
    if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL read_release: rsp_valid=%b cmd_ready=%b required 0 1", o_rsp_valid, o_cmd_ready);
    end
  endtask

  task automatic test_write;
    int cnt; logic [31:0] d; logic e, got; rsp_t x;
    exp_q.push_back('{d: 32'h0, e: 1'b0});
    send_cmd(1'b1, 32'h0000_0000, 32'h1234_5678);
    checks++;
    if (o_wbm_cyc !== 1'b1 || o_wbm_we !== 1'b1 || o_wbm_data !== 32'h1234_5678) begin
      errors++; $display("FAIL write_bus: cyc=%b we=%b data=%h required 1 1 12345678",
                         o_wbm_cyc, o_wbm_we, o_wbm_data);
    end
    run_bus(1, 32'hDEAD_BEEF, cnt);
    checks++;
    if (cnt != 1) begin errors++; $display("FAIL write_cyc_len: got %0d required 1", cnt); end
    drain_rsp(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (got !== 1'b1 || d !== x.d || e !== x.e) begin
      errors++; $display("FAIL write_rsp: valid=%b data=%h err=%b required 1 %h %b", got, d, e, x.d, x.e);
    end
  endtask

  task automatic test_decode_err;
    int cnt; logic [31:0] d; logic e, got; rsp_t x;
    exp_q.push_back('{d: 32'h0, e: 1'b1});
    exp_err_cnt++;
    send_cmd(1'b0, 32'h0000_0300, 32'h0);
    run_bus(1, 32'h5555_5555, cnt);
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL decode_no_cyc: cyc cycles %0d required 0", cnt); end
    drain_rsp(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (got !== 1'b1 || d !== x.d || e !== x.e) begin
      errors++; $display("FAIL decode_rsp: valid=%b data=%h err=%b required 1 %h %b", got, d, e, x.d, x.e);
    end
    checks++;
    if (o_err_cnt !== 8'(exp_err_cnt)) begin
      errors++; $display("FAIL decode_err_cnt: got %0d required %0d", o_err_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_timeout;
    int cnt; logic [31:0] d; logic e, got; rsp_t x;
    // No ack: abort after exactly TIMEOUT cycles.
    exp_q.push_back('{d: 32'h0, e: 1'b1});
    exp_err_cnt++;
    send_cmd(1'b0, 32'h0000_0200, 32'h0);
    run_bus(0, 32'h0, cnt);
    checks++;
    if (cnt != 8) begin errors++; $display("FAIL timeout_len: got %0d required 8", cnt); end
    drain_rsp(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (got !== 1'b1 || d !== x.d || e !== x.e) begin
      errors++; $display("FAIL timeout_rsp: valid=%b data=%h err=%b required 1 %h %b", got, d, e, x.d, x.e);
    end
    // Ack on the final cycle wins over the timeout.
    exp_q.push_back('{d: 32'h0BAD_C0DE, e: 1'b0});
    send_cmd(1'b0, 32'h0000_0100, 32'h0);
    run_bus(8, 32'h0BAD_C0DE, cnt);
    checks++;
    if (cnt != 8) begin errors++; $display("FAIL late_ack_len: got %0d required 8", cnt); end
    drain_rsp(d, e, got);
    x = exp_q.pop_front();
    checks++;
    if (got !== 1'b1 || d !== x.d || e !== x.e) begin
      errors++; $display("FAIL late_ack_rsp: valid=%b data=%h err=%b required 1 %h %b", got, d, e, x.d, x.e);
    end
    checks++;
    if (o_err_cnt !== 8'(exp_err_cnt)) begin
      errors++; $display("FAIL timeout_err_cnt: got %0d required %0d", o_err_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_backpressure;
    int cnt; rsp_t x; logic stable;
    exp_q.push_back('{d: 32'hA5A5_5A5A, e: 1'b0});
    send_cmd(1'b0, 32'h0000_0000, 32'h0);
    run_bus(1, 32'hA5A5_5A5A, cnt);
    x = exp_q.pop_front();
    // A second command waits on the input the whole time.
    i_cmd_we = 1'b1; i_cmd_addr = 32'h0000_0100; i_cmd_data = 32'h7777_7777; i_cmd_valid = 1'b1;
    stable = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== x.d || o_rsp_err !== x.e ||
          o_cmd_ready !== 1'b0 || o_wbm_cyc !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++; $display("FAIL bp_hold: valid=%b data=%h err=%b ready=%b cyc=%b required 1 %h %b 0 0",
                         o_rsp_valid, o_rsp_data, o_rsp_err, o_cmd_ready, o_wbm_cyc, x.d, x.e);
    end
    // Release the response with the command still pending: not taken on that edge.
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    i_cmd_valid = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_wbm_cyc !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: rsp_valid=%b cyc=%b cmd_ready=%b required 0 0 1",
                         o_rsp_valid, o_wbm_cyc, o_cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    int rsp_seen; logic [31:0] d; rsp_t x;
    rsp_seen = 0;
    i_rsp_ready = 1'b1; i_wbm_ack = 1'b1;
    i_cmd_we = 1'b0; i_cmd_addr = 32'h0000_0200; i_cmd_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        rsp_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected: data=%h err=%b required no response", o_rsp_data, o_rsp_err);
        end else begin
          x = exp_q.pop_front();
          if (o_rsp_data !== x.d || o_rsp_err !== x.e) begin
            errors++; $display("FAIL b2b_rsp: data=%h err=%b required %h %b", o_rsp_data, o_rsp_err, x.d, x.e);
          end
        end
      end
      d = $urandom;
      i_wbm_data = d;
      if (o_wbm_cyc) exp_q.push_back('{d: d, e: 1'b0});
    end
    i_cmd_valid = 1'b0; i_wbm_ack = 1'b0; i_rsp_ready = 1'b0;
    checks++;
    if (rsp_seen != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_rate: responses %0d pending %0d required 4 0", rsp_seen, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_bus;
    logic quiet;
    send_cmd(1'b0, 32'h0000_0100, 32'h0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (o_wbm_cyc !== 1'b0 || o_wbm_stb !== 1'b0 || o_rsp_valid !== 1'b0 || o_err_cnt !== 8'h0) begin
      errors++; $display("FAIL rst_mid_bus: cyc=%b stb=%b rsp_valid=%b err_cnt=%0d required 0 0 0 0",
                         o_wbm_cyc, o_wbm_stb, o_rsp_valid, o_err_cnt);
    end
    exp_err_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: cmd_ready=%b required 1", o_cmd_ready);
    end
    quiet = 1'b1;
    i_wbm_ack = 1'b1; i_rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (o_rsp_valid !== 1'b0 || o_wbm_cyc !== 1'b0) quiet = 1'b0;
    end
    i_wbm_ack = 1'b0; i_rsp_ready = 1'b0;
    checks++;
    if (quiet !== 1'b1) begin
      errors++; $display("FAIL rst_mid_no_rsp: rsp_valid=%b cyc=%b required 0 0", o_rsp_valid, o_wbm_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_decode_err();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
